pipe_stage_skid: RTL and testbench

PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

---
 rtl/pipe_stage_skid.sv | 91 +++++++++
 tb/tb_pipe_stage_skid.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: two-entry (main + skid) pipeline register with registered in_ready, flush and optional stats (PIPE_STAGE_STATS_EN).
module pipe_stage_skid #(
  parameter int DATA_W = 16,
  parameter int CTRL_W = 12,
  parameter logic [CTRL_W-1:0] BUBBLE_CTRL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [15:0]       stall_cnt,
  output logic [15:0]       flush_cnt
);
  localparam int P_W = DATA_W + CTRL_W;
  logic           main_v_q, main_v_d, skid_v_q, skid_v_d, in_ready_q, in_ready_d;
  logic [P_W-1:0] main_q, main_d, skid_q, skid_d;
  logic           accept, consume;
  assign accept  = in_valid && in_ready_q;
  assign consume = main_v_q && out_ready;
  always_comb begin
    main_v_d = main_v_q;
    skid_v_d = skid_v_q;
    main_d   = main_q;
    skid_d   = skid_q;
    if (flush) begin
      main_v_d = 1'b0;
      skid_v_d = 1'b0;
    end else if (consume) begin
      if (skid_v_q) begin
        main_d   = skid_q;
        skid_v_d = 1'b0;
      end else if (accept) main_d = {in_ctrl, in_data};
      else main_v_d = 1'b0;
    end else if (accept) begin
      if (main_v_q) begin
        skid_d   = {in_ctrl, in_data};
        skid_v_d = 1'b1;
      end else begin
        main_d   = {in_ctrl, in_data};
        main_v_d = 1'b1;
      end
    end
    in_ready_d = !skid_v_d;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      main_v_q   <= 1'b0;
      skid_v_q   <= 1'b0;
      in_ready_q <= 1'b1;
      main_q     <= '0;
      skid_q     <= '0;
    end else begin
      main_v_q   <= main_v_d;
      skid_v_q   <= skid_v_d;
      in_ready_q <= in_ready_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
    end
  assign in_ready  = in_ready_q;
  assign out_valid = main_v_q;
  assign out_data  = main_v_q ? main_q[DATA_W-1:0] : '0;
  assign out_ctrl  = main_v_q ? main_q[P_W-1:DATA_W] : BUBBLE_CTRL;
`ifdef PIPE_STAGE_STATS_EN
  logic [15:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  // Both counters saturate rather than wrap
  always_comb begin
    stall_cnt_d = (main_v_q && !out_ready && stall_cnt_q != 16'hFFFF) ? stall_cnt_q + 16'd1 : stall_cnt_q;
    flush_cnt_d = (flush && (main_v_q || skid_v_q) && flush_cnt_q != 16'hFFFF) ? flush_cnt_q + 16'd1 : flush_cnt_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = 16'h0;
  assign flush_cnt = 16'h0;
`endif
endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb_pipe_stage_skid: directed scenarios plus random traffic checked against a depth-2 FIFO model.
module tb_pipe_stage_skid;
  localparam int DW = 16;
  localparam int CW = 12;
  localparam logic [CW-1:0] BUB = 12'h5A3;
  logic clk = 0, rst = 1, flush = 0, in_valid = 0, out_ready = 1;
  logic [DW-1:0] in_data = '0;
  logic [CW-1:0] in_ctrl = '0;
  logic in_ready, out_valid;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_ctrl;
  logic [15:0] stall_cnt, flush_cnt;
  int n_chk = 0, n_fail = 0;
  logic [DW+CW-1:0] q[$];
  int m_stall = 0, m_flush = 0;
  bit stats;

  pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .BUBBLE_CTRL(BUB)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ctrl(out_ctrl), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt));

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Reference: the stage behaves as a 2-deep FIFO whose head is presented
  always @(posedge clk or posedge rst)
    if (rst) begin
      q.delete();
      m_stall = 0;
      m_flush = 0;
    end else begin
      automatic bit acc = in_valid && q.size() < 2;
      automatic bit con = q.size() > 0 && out_ready;
      if (q.size() > 0 && !out_ready && m_stall < 65535) m_stall++;
      if (flush) begin
        if (q.size() > 0 && m_flush < 65535) m_flush++;
        q.delete();
      end else begin
        if (con) void'(q.pop_front());
        if (acc) q.push_back({in_ctrl, in_data});
      end
    end

  always @(negedge clk)
    if (!rst) begin
      chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
      chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
      chk("out_data", 32'(out_data), q.size() > 0 ? 32'(q[0][DW-1:0]) : 32'h0);
      chk("out_ctrl", 32'(out_ctrl), q.size() > 0 ? 32'(q[0][DW+CW-1:DW]) : 32'(BUB));
      chk("stall_cnt", 32'(stall_cnt), stats ? 32'(m_stall) : 32'h0);
      chk("flush_cnt", 32'(flush_cnt), stats ? 32'(m_flush) : 32'h0);
    end

  task automatic offer(input logic [DW-1:0] d, input logic [CW-1:0] c);
    in_valid = 1; in_data = d; in_ctrl = c;
    cyc();
    in_valid = 0;
  endtask

  initial begin
`ifdef PIPE_STAGE_STATS_EN
    stats = 1;
`else
    stats = 0;
`endif
    cyc(2);
    rst = 0;
    chk("rst_in_ready", 32'(in_ready), 32'h1);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_ctrl", 32'(out_ctrl), 32'(BUB));
    chk("rst_out_data", 32'(out_data), 32'h0);
    // one-cycle latency
    offer(16'h1234, 12'h0A5);
    chk("lat_valid", 32'(out_valid), 32'h1);
    chk("lat_data", 32'(out_data), 32'h1234);
    chk("lat_ctrl", 32'(out_ctrl), 32'h0A5);
    chk("lat_in_ready", 32'(in_ready), 32'h1);
    cyc();
    chk("lat_drained", 32'(out_valid), 32'h0);
    // fill to FULL then drain
    out_ready = 0;
    offer(16'h0001, 12'h001);
    chk("full_rdy_after_a", 32'(in_ready), 32'h1);
    offer(16'h0002, 12'h002);
    chk("full_in_ready", 32'(in_ready), 32'h0);
    chk("full_head", 32'(out_data), 32'h0001);
    out_ready = 1;
    cyc();
    chk("drain_b", 32'(out_data), 32'h0002);
    chk("drain_rdy", 32'(in_ready), 32'h1);
    cyc();
    chk("drain_empty", 32'(out_valid), 32'h0);
    // flush in FULL with a same-cycle offer
    out_ready = 0;
    offer(16'h000A, 12'h00A);
    offer(16'h000B, 12'h00B);
    in_valid = 1; in_data = 16'h0003; in_ctrl = 12'h003; flush = 1;
    cyc();
    flush = 0; in_valid = 0;
    chk("flush_valid", 32'(out_valid), 32'h0);
    chk("flush_ctrl", 32'(out_ctrl), 32'(BUB));
    chk("flush_rdy", 32'(in_ready), 32'h1);
    chk("flush_cnt_lit", 32'(flush_cnt), stats ? 32'h1 : 32'h0);
    out_ready = 1;
    cyc(3);
    chk("flush_no_c", 32'(out_valid), 32'h0);
    // ramp at full throughput, counters cleared first
    rst = 1; cyc(); rst = 0;
    for (int i = 0; i < 100; i++) begin
      in_valid = 1; in_data = DW'(i); in_ctrl = CW'(i);
      cyc();
      chk("ramp_valid", 32'(out_valid), 32'h1);
      chk("ramp_data", 32'(out_data), i);
    end
    in_valid = 0;
    cyc();
    chk("ramp_stall", 32'(stall_cnt), 32'h0);
    // long stall saturates
    out_ready = 0;
    offer(16'h0077, 12'h077);
    cyc(70000);
    chk("sat_stall", 32'(stall_cnt), stats ? 32'hFFFF : 32'h0);
    chk("sat_flush", 32'(flush_cnt), 32'h0);
    chk("sat_hold", 32'(out_data), 32'h0077);
    out_ready = 1;
    cyc();
    // async reset between edges while FULL
    out_ready = 0;
    offer(16'h0011, 12'h011);
    offer(16'h0022, 12'h022);
    #1 rst = 1;
    #1;
    chk("arst_valid", 32'(out_valid), 32'h0);
    chk("arst_rdy", 32'(in_ready), 32'h1);
    chk("arst_ctrl", 32'(out_ctrl), 32'(BUB));
    chk("arst_data", 32'(out_data), 32'h0);
    chk("arst_stall", 32'(stall_cnt), 32'h0);
    cyc();
    rst = 0; out_ready = 1;
    offer(16'h0055, 12'h055);
    chk("arst_first", 32'(out_data), 32'h0055);
    cyc();
    chk("arst_gone", 32'(out_valid), 32'h0);
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 19) == 0);
      in_data = DW'($urandom);
      in_ctrl = CW'($urandom);
      cyc();
    end
    in_valid = 0; flush = 0; out_ready = 1;
    cyc(3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
